// File: rtl/ifu_pkg.sv
// ============================================================================
// Module : ifu_pkg
// Brief  : Shared types and constants for the instruction fetch unit.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package ifu_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2
    } state_t;

    localparam logic [31:0] C_RESET_PC = 32'h0000_3000;

    localparam logic [5:0] C_OP_RTYPE = 6'b000000;
    localparam logic [5:0] C_OP_ORI   = 6'b001101;
    localparam logic [5:0] C_OP_LW    = 6'b100011;
    localparam logic [5:0] C_OP_SW    = 6'b101011;
    localparam logic [5:0] C_OP_BEQ   = 6'b000100;
    localparam logic [5:0] C_OP_J     = 6'b000010;

endpackage

`default_nettype wire

// File: rtl/npc.sv
// ============================================================================
// Module : npc
// Brief  : Combinational next-PC select (jump > taken branch > pc+4).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module npc (
    input  logic [31:0] i_pc,
    input  logic [25:0] i_index,
    input  logic        i_jump,
    input  logic        i_branch,
    input  logic        i_zero,
    output logic [31:0] o_npc
);

    logic [31:0] w_pc_plus4;
    logic [31:0] w_br_off;
    logic [31:0] w_br_target;
    logic [31:0] w_j_target;

    assign w_pc_plus4  = i_pc + 32'd4;
    // The branch offset field is the low 16 bits of the jump index field.
    assign w_br_off    = {{14{i_index[15]}}, i_index[15:0], 2'b00};
    assign w_br_target = w_pc_plus4 + w_br_off;
    assign w_j_target  = {w_pc_plus4[31:28], i_index, 2'b00};

    always_comb begin
        o_npc = w_pc_plus4;
        if (i_jump)
            o_npc = w_j_target;
        else if (i_branch && i_zero)
            o_npc = w_br_target;
    end

endmodule

`default_nettype wire

// File: rtl/instr_fetch_unit.sv
// ============================================================================
// Module : instr_fetch_unit
// Brief  : Fetches one word per instruction and holds it until retired.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module instr_fetch_unit
    import ifu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = C_RESET_PC
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [5:0]  op,
    output logic [5:0]  funct,
    input  logic        jump,
    input  logic        branch,
    input  logic        zero,
    output logic [31:0] pc,
    output logic [31:0] retire_cnt
);

    state_t      r_state;
    logic        r_req;
    logic        r_valid;
    logic [31:0] r_pc;
    logic [31:0] r_instr;
    logic [31:0] r_retire_cnt;
    logic [31:0] w_npc;

    npc u_npc (
        .i_pc     (r_pc),
        .i_index  (r_instr[25:0]),
        .i_jump   (jump),
        .i_branch (branch),
        .i_zero   (zero),
        .o_npc    (w_npc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_req        <= 1'b0;
            r_valid      <= 1'b0;
            r_pc         <= {RESET_PC[31:2], 2'b00};
            r_instr      <= 32'd0;
            r_retire_cnt <= 32'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_state <= FETCH;
                    r_req   <= 1'b1;
                end
                FETCH: begin
                    if (imem_ack) begin
                        r_instr <= imem_rdata;
                        r_valid <= 1'b1;
                        r_req   <= 1'b0;
                        r_state <= HOLD;
                    end
                end
                HOLD: begin
                    // Redirect controls only matter in the retire cycle.
                    if (instr_ready) begin
                        r_pc         <= w_npc;
                        r_retire_cnt <= r_retire_cnt + 32'd1;
                        r_valid      <= 1'b0;
                        r_req        <= 1'b1;
                        r_state      <= FETCH;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_req   <= 1'b0;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

    assign imem_req    = r_req;
    assign imem_addr   = r_pc;
    assign instr_valid = r_valid;
    assign instr       = r_instr;
    assign op          = r_instr[31:26];
    assign funct       = r_instr[5:0];
    assign pc          = r_pc;
    assign retire_cnt  = r_retire_cnt;

endmodule

`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
// ============================================================================
// Module : tb_instr_fetch_unit
// Brief  : Directed self-checking bench for instr_fetch_unit.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [5:0]  op;
    logic [5:0]  funct;
    logic        jump, branch, zero;
    logic [31:0] pc;
    logic [31:0] retire_cnt;

    // Standalone next-PC instance for wrap cases unreachable from RESET_PC.
    logic [31:0] n_pc;
    logic [25:0] n_index;
    logic        n_jump, n_branch, n_zero;
    logic [31:0] n_out;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    instr_fetch_unit #(.RESET_PC(32'h0000_3000)) dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .op          (op),
        .funct       (funct),
        .jump        (jump),
        .branch      (branch),
        .zero        (zero),
        .pc          (pc),
        .retire_cnt  (retire_cnt)
    );

    npc u_npc_ref (
        .i_pc     (n_pc),
        .i_index  (n_index),
        .i_jump   (n_jump),
        .i_branch (n_branch),
        .i_zero   (n_zero),
        .o_npc    (n_out)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Waits for a request at exp_addr, acks after `lat` request cycles.
    task automatic fetch(input logic [31:0] exp_addr, input logic [31:0] word, input int lat);
        int guard = 0;
        while (imem_req !== 1'b1 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        chk("fetch_req_seen", {31'd0, imem_req}, 32'd1);
        for (int i = 1; i <= lat; i++) begin
            chk("fetch_addr", imem_addr, exp_addr);
            chk("fetch_valid_low", {31'd0, instr_valid}, 32'd0);
            if (i == lat) begin
                imem_ack   = 1'b1;
                imem_rdata = word;
            end
            @(negedge clk);
        end
        imem_ack   = 1'b0;
        imem_rdata = 32'hDEAD_BEEF;
        chk("fetch_valid", {31'd0, instr_valid}, 32'd1);
        chk("fetch_instr", instr, word);
        chk("fetch_req_drop", {31'd0, imem_req}, 32'd0);
    endtask

    task automatic retire(input logic j, input logic b, input logic z,
                          input logic [31:0] exp_pc, input logic [31:0] exp_cnt);
        instr_ready = 1'b1;
        jump = j; branch = b; zero = z;
        @(negedge clk);
        instr_ready = 1'b0;
        jump = 1'b0; branch = 1'b0; zero = 1'b0;
        chk("retire_pc", pc, exp_pc);
        chk("retire_cnt", retire_cnt, exp_cnt);
        chk("retire_valid_low", {31'd0, instr_valid}, 32'd0);
    endtask

    initial begin
        rst = 1'b1; imem_ack = 1'b0; imem_rdata = 32'd0; instr_ready = 1'b0;
        jump = 1'b0; branch = 1'b0; zero = 1'b0;
        n_pc = 32'd0; n_index = 26'd0; n_jump = 1'b0; n_branch = 1'b0; n_zero = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_pc", pc, 32'h0000_3000);
        chk("rst_instr", instr, 32'd0);
        chk("rst_cnt", retire_cnt, 32'd0);
        chk("rst_req", {31'd0, imem_req}, 32'd0);
        chk("rst_valid", {31'd0, instr_valid}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Ack on the third request cycle; address must not move meanwhile.
        fetch(32'h3000, 32'h0000_0020, 3);
        retire(1'b0, 1'b0, 1'b0, 32'h3004, 32'd1);
        fetch(32'h3004, 32'h0000_0021, 1);
        retire(1'b0, 1'b0, 1'b0, 32'h3008, 32'd2);

        // BEQ with offset -1 lands back on itself when taken.
        fetch(32'h3008, 32'h1000_FFFF, 2);
        chk("beq_op", {26'd0, op}, 32'h04);
        chk("beq_funct", {26'd0, funct}, 32'h3F);
        retire(1'b0, 1'b1, 1'b1, 32'h3008, 32'd3);
        fetch(32'h3008, 32'h1000_FFFF, 1);
        retire(1'b0, 1'b1, 1'b0, 32'h300C, 32'd4);
        fetch(32'h300C, 32'h0000_0000, 1);
        retire(1'b0, 1'b0, 1'b0, 32'h3010, 32'd5);

        fetch(32'h3010, 32'h0800_0C00, 1);
        chk("j_op", {26'd0, op}, 32'h02);
        retire(1'b1, 1'b1, 1'b1, 32'h3000, 32'd6);

        // Stall in HOLD with stray acks and redirect noise present.
        fetch(32'h3000, 32'h3421_0005, 2);
        for (int i = 0; i < 5; i++) begin
            imem_ack = 1'b1; imem_rdata = 32'h1234_5678;
            jump = 1'b1; branch = 1'b1; zero = 1'b1;
            @(negedge clk);
            chk("hold_instr", instr, 32'h3421_0005);
            chk("hold_op", {26'd0, op}, 32'h0D);
            chk("hold_pc", pc, 32'h3000);
            chk("hold_req", {31'd0, imem_req}, 32'd0);
            chk("hold_valid", {31'd0, instr_valid}, 32'd1);
        end
        imem_ack = 1'b0; jump = 1'b0; branch = 1'b0; zero = 1'b0;
        retire(1'b0, 1'b0, 1'b0, 32'h3004, 32'd7);

        // Reset mid-fetch with an ack asserted through reset and IDLE.
        chk("pre_rst_req", {31'd0, imem_req}, 32'd1);
        rst = 1'b1; imem_ack = 1'b1; imem_rdata = 32'hCAFE_F00D;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_pc", pc, 32'h3000);
        chk("midrst_valid", {31'd0, instr_valid}, 32'd0);
        chk("midrst_instr", instr, 32'd0);
        @(negedge clk);
        imem_ack = 1'b0;
        chk("idle_ack_valid", {31'd0, instr_valid}, 32'd0);
        chk("idle_ack_instr", instr, 32'd0);
        chk("idle_ack_req", {31'd0, imem_req}, 32'd1);
        chk("idle_ack_cnt", retire_cnt, 32'd0);

        // Retire counter wrap via a preloaded count.
        fetch(32'h3000, 32'h8C22_0004, 1);
        force dut.r_retire_cnt = 32'hFFFF_FFFF;
        #1;
        release dut.r_retire_cnt;
        retire(1'b0, 1'b0, 1'b0, 32'h3004, 32'd0);

        n_pc = 32'hFFFF_FFFC; n_index = 26'h000_0010;
        #1 chk("npc_wrap", n_out, 32'h0000_0000);
        n_pc = 32'h0000_0000; n_index = 26'h000_8000; n_branch = 1'b1; n_zero = 1'b1;
        #1 chk("npc_br_neg_wrap", n_out, 32'hFFFE_0004);
        n_pc = 32'hA000_0010; n_index = 26'h3FF_FFFF; n_jump = 1'b1;
        #1 chk("npc_j_upper", n_out, 32'hAFFF_FFFC);
        n_jump = 1'b0; n_zero = 1'b0;
        #1 chk("npc_br_nz", n_out, 32'hA000_0014);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule

`default_nettype wire
